// File: rtl/dca_lsu_merger_pkg.sv
// ============================================================================
// dca_lsu_merger_pkg : arbiter state encoding and width helpers for the merger
// Rev 1.0
// ============================================================================
`default_nettype none

package dca_lsu_merger_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Port-index width; one bit minimum so a single-port build still elaborates
  function automatic int idx_width(input int num_port);
    return (num_port > 1) ? $clog2(num_port) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dca_lsu_merger_tag_fifo.sv
// ============================================================================
// dca_lsu_merger_tag_fifo : ordering FIFO holding the owner port of each burst
// Rev 1.0
// ============================================================================
`default_nettype none

module dca_lsu_merger_tag_fifo
  import dca_lsu_merger_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstnn,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int BW_CNT = cnt_width(DEPTH);
  localparam int BW_PTR = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [BW_PTR-1:0] wr_ptr_q;
  logic [BW_PTR-1:0] rd_ptr_q;
  logic [BW_CNT-1:0] cnt_q;
  logic              w_do_push;
  logic              w_do_pop;

  assign full_o    = (cnt_q == BW_CNT'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign head_o    = mem_q[rd_ptr_q];
  assign w_do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + BW_PTR'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + BW_PTR'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   cnt_q <= cnt_q + BW_CNT'(1);
        2'b01:   cnt_q <= cnt_q - BW_CNT'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/dca_lsu_xmi_merger.sv
// ============================================================================
// dca_lsu_xmi_merger : N LPI ports onto one XMI port, burst round-robin with
// per-direction ordering FIFOs. DCA_LSU_MERGER_PRIORITY_EN: port 0 strict prio.
// Rev 1.0
// ============================================================================
`default_nettype none

module dca_lsu_xmi_merger
  import dca_lsu_merger_pkg::*;
#(
  parameter int NUM_PORT      = 4,
  parameter int BW_LPI_QDATA  = 64,
  parameter int BW_LPI_YDATA  = 40,
  parameter int WRITE_BIT_POS = 0,
  parameter int DEPTH         = 8
) (
  input  logic                             clk,
  input  logic                             rstnn,
  input  logic                             clear,
  output logic                             busy,
  output logic                             unexpected_resp,
  input  logic [NUM_PORT-1:0]              port_qvalid,
  input  logic [NUM_PORT-1:0]              port_qlast,
  input  logic [NUM_PORT*BW_LPI_QDATA-1:0] port_qdata,
  output logic [NUM_PORT*2-1:0]            port_qdready,
  output logic [NUM_PORT-1:0]              port_yvalid,
  output logic [NUM_PORT-1:0]              port_ylast,
  output logic [BW_LPI_YDATA-1:0]          port_ydata,
  input  logic [NUM_PORT*2-1:0]            port_ydready,
  output logic                             slxqvalid,
  output logic                             slxqlast,
  output logic [BW_LPI_QDATA-1:0]          slxqdata,
  input  logic [1:0]                       slxqdready,
  input  logic                             slxyvalid,
  input  logic                             slxylast,
  input  logic                             slxywreply,
  input  logic [BW_LPI_YDATA-1:0]          slxydata,
  output logic [1:0]                       slxydready
);

  localparam int BW_PORT_IDX = idx_width(NUM_PORT);

  arb_state_e              state_q, state_d;
  logic [BW_PORT_IDX-1:0]  grant_q, grant_d;
  logic [BW_PORT_IDX-1:0]  rr_ptr_q, rr_ptr_d;
  logic                    unexpected_q;

  logic [NUM_PORT-1:0]     elig;
  logic                    cand_found;
  logic [BW_PORT_IDX-1:0]  cand_idx;
  logic                    gnt_valid;
  logic [BW_PORT_IDX-1:0]  gnt_idx;
  logic                    sel_qvalid, sel_qlast, q_xfer;
  logic [BW_LPI_QDATA-1:0] sel_qdata;
  logic                    rpush, wpush, rpop, wpop;
  logic                    rfull, wfull, rempty, wempty;
  logic [BW_PORT_IDX-1:0]  rhead, whead, sel_head;
  logic                    sel_empty, y_xfer;

  // A port is eligible only while the FIFO of its direction has room
  for (genvar i = 0; i < NUM_PORT; i++) begin : g_elig
    assign elig[i] = port_qvalid[i] &
                     (port_qdata[i*BW_LPI_QDATA + WRITE_BIT_POS] ? ~wfull : ~rfull);
  end

  always_comb begin
    int                     j;
    logic [BW_PORT_IDX-1:0] jj;
    cand_found = 1'b0;
    cand_idx   = '0;
    j          = 0;
    jj         = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_PORT) j = j - NUM_PORT;
      jj = BW_PORT_IDX'(j);
      if (!cand_found && elig[jj]) begin
        cand_found = 1'b1;
        cand_idx   = jj;
      end
    end
`ifdef DCA_LSU_MERGER_PRIORITY_EN
    if (elig[0]) begin
      cand_found = 1'b1;
      cand_idx   = '0;
    end
`endif
  end

  assign gnt_valid = (state_q == ARB_LOCKED) | cand_found;
  assign gnt_idx   = (state_q == ARB_LOCKED) ? grant_q : cand_idx;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    rpush        = 1'b0;
    wpush        = 1'b0;
    sel_qvalid   = 1'b0;
    sel_qlast    = 1'b0;
    sel_qdata    = '0;
    port_qdready = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (gnt_valid && gnt_idx == BW_PORT_IDX'(i)) begin
        sel_qvalid               = port_qvalid[i];
        sel_qlast                = port_qlast[i];
        sel_qdata                = port_qdata[i*BW_LPI_QDATA +: BW_LPI_QDATA];
        port_qdready[2*i +: 2]   = slxqdready;
      end
    end
    q_xfer = sel_qvalid & slxqdready[0];
    if (q_xfer) begin
      if (state_q == ARB_IDLE) begin
        wpush = sel_qdata[WRITE_BIT_POS];
        rpush = ~sel_qdata[WRITE_BIT_POS];
        if (!sel_qlast) begin
          state_d = ARB_LOCKED;
          grant_d = gnt_idx;
        end
      end
      if (sel_qlast) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = (gnt_idx == BW_PORT_IDX'(NUM_PORT - 1)) ? '0
                                                           : gnt_idx + BW_PORT_IDX'(1);
      end
    end
  end

  assign slxqvalid = sel_qvalid;
  assign slxqlast  = sel_qlast;
  assign slxqdata  = sel_qdata;

  assign sel_empty = slxywreply ? wempty : rempty;
  assign sel_head  = slxywreply ? whead  : rhead;

  // With no owner on record the reply is drained so the interconnect never stalls
  always_comb begin
    port_yvalid = '0;
    port_ylast  = '0;
    slxydready  = 2'b11;
    if (!sel_empty) begin
      slxydready = 2'b00;
      for (int i = 0; i < NUM_PORT; i++) begin
        if (sel_head == BW_PORT_IDX'(i)) begin
          port_yvalid[i] = slxyvalid;
          port_ylast[i]  = slxylast;
          slxydready     = port_ydready[2*i +: 2];
        end
      end
    end
    y_xfer = slxyvalid & slxydready[0] & ~sel_empty;
    rpop   = y_xfer & ~slxywreply & slxylast;
    wpop   = y_xfer & slxywreply;
  end

  assign port_ydata      = slxydata;
  assign unexpected_resp = unexpected_q;
  assign busy            = (state_q == ARB_LOCKED) | ~rempty | ~wempty;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      unexpected_q <= 1'b0;
    end else if (clear) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      unexpected_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      if (slxyvalid && sel_empty) unexpected_q <= 1'b1;
    end
  end

  dca_lsu_merger_tag_fifo #(
    .WIDTH (BW_PORT_IDX),
    .DEPTH (DEPTH)
  ) u_rfifo (
    .clk         (clk),
    .rstnn       (rstnn),
    .clear_i     (clear),
    .push_i      (rpush),
    .push_data_i (gnt_idx),
    .pop_i       (rpop),
    .full_o      (rfull),
    .empty_o     (rempty),
    .head_o      (rhead)
  );

  dca_lsu_merger_tag_fifo #(
    .WIDTH (BW_PORT_IDX),
    .DEPTH (DEPTH)
  ) u_wfifo (
    .clk         (clk),
    .rstnn       (rstnn),
    .clear_i     (clear),
    .push_i      (wpush),
    .push_data_i (gnt_idx),
    .pop_i       (wpop),
    .full_o      (wfull),
    .empty_o     (wempty),
    .head_o      (whead)
  );

endmodule

`default_nettype wire

// File: tb/tb_dca_lsu_xmi_merger.sv
// ============================================================================
// tb_dca_lsu_xmi_merger : directed self-checking bench for dca_lsu_xmi_merger
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dca_lsu_xmi_merger;

  logic         clk;
  logic         rstnn;
  logic         clear;
  logic         busy;
  logic         unexpected_resp;
  logic [3:0]   port_qvalid;
  logic [3:0]   port_qlast;
  logic [255:0] port_qdata;
  logic [7:0]   port_qdready;
  logic [3:0]   port_yvalid;
  logic [3:0]   port_ylast;
  logic [39:0]  port_ydata;
  logic [7:0]   port_ydready;
  logic         slxqvalid;
  logic         slxqlast;
  logic [63:0]  slxqdata;
  logic [1:0]   slxqdready;
  logic         slxyvalid;
  logic         slxylast;
  logic         slxywreply;
  logic [39:0]  slxydata;
  logic [1:0]   slxydready;

  int n_checks;
  int n_errors;

  dca_lsu_xmi_merger u_dut (
    .clk             (clk),
    .rstnn           (rstnn),
    .clear           (clear),
    .busy            (busy),
    .unexpected_resp (unexpected_resp),
    .port_qvalid     (port_qvalid),
    .port_qlast      (port_qlast),
    .port_qdata      (port_qdata),
    .port_qdready    (port_qdready),
    .port_yvalid     (port_yvalid),
    .port_ylast      (port_ylast),
    .port_ydata      (port_ydata),
    .port_ydready    (port_ydready),
    .slxqvalid       (slxqvalid),
    .slxqlast        (slxqlast),
    .slxqdata        (slxqdata),
    .slxqdready      (slxqdready),
    .slxyvalid       (slxyvalid),
    .slxylast        (slxylast),
    .slxywreply      (slxywreply),
    .slxydata        (slxydata),
    .slxydready      (slxydready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_qdata(input int idx, input logic [63:0] val);
    port_qdata[idx*64 +: 64] = val;
  endtask

  initial begin
    logic [7:0] exp_rdy;
    logic [3:0] exp_v;
    n_checks     = 0;
    n_errors     = 0;
    rstnn        = 1'b0;
    clear        = 1'b0;
    port_qvalid  = '0;
    port_qlast   = '0;
    port_qdata   = '0;
    port_ydready = 8'h55;
    slxqdready   = 2'b11;
    slxyvalid    = 1'b0;
    slxylast     = 1'b0;
    slxywreply   = 1'b0;
    slxydata     = 40'h12_3456_789A;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_unexp", 64'(unexpected_resp), 64'd0);
    check("rst_qdready", 64'(port_qdready), 64'd0);
    check("rst_yvalid", 64'(port_yvalid), 64'd0);
    check("rst_slxqvalid", 64'(slxqvalid), 64'd0);
    @(negedge clk);
    rstnn = 1'b1;

    // Four simultaneous single-beat reads, granted 0,1,2,3
    for (int i = 0; i < 4; i++) set_qdata(i, 64'h1000 + 64'(i * 16));
    port_qlast = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      port_qvalid = 4'hF & (4'hF << i);
      #1;
      exp_rdy = 8'h3 << (2 * i);
      check("t1_qdready", 64'(port_qdready), 64'(exp_rdy));
      check("t1_qdata", slxqdata, 64'h1000 + 64'(i * 16));
    end
    @(negedge clk);
    port_qvalid = '0;
    #1;
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_slxqvalid", 64'(slxqvalid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      slxyvalid  = 1'b1;
      slxylast   = 1'b1;
      slxywreply = 1'b0;
      #1;
      exp_v = 4'h1 << i;
      check("t1_yvalid", 64'(port_yvalid), 64'(exp_v));
      check("t1_ydready", 64'(slxydready), 64'd1);
    end
    check("t1_ydata", 64'(port_ydata), 64'h12_3456_789A);
    @(negedge clk);
    slxyvalid = 1'b0;
    #1;
    check("t1_idle", 64'(busy), 64'd0);

    // Port 1 four-beat write holds the lock against port 2
    set_qdata(1, 64'h2001);
    set_qdata(2, 64'h3000);
    port_qlast = 4'b0100;
    @(negedge clk);
    port_qvalid = 4'b0110;
    #1;
    check("t2_beat0", 64'(port_qdready), 64'h0C);
    @(negedge clk);
    port_qvalid = 4'b0100;
    #1;
    check("t2_drop_valid", 64'(slxqvalid), 64'd0);
    check("t2_drop_rdy", 64'(port_qdready), 64'h0C);
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      port_qvalid = 4'b0110;
      if (b == 3) port_qlast = 4'b0110;
      #1;
      check("t2_beat", 64'(port_qdready), 64'h0C);
    end
    check("t2_last", 64'(slxqlast), 64'd1);
    @(negedge clk);
    port_qvalid = 4'b0100;
    #1;
    check("t2_p2_grant", 64'(port_qdready), 64'h30);
    check("t2_p2_data", slxqdata, 64'h3000);
    @(negedge clk);
    port_qvalid = '0;
    port_qlast  = '0;

    // Read data and write reply routed independently
    @(negedge clk);
    slxyvalid = 1'b1; slxywreply = 1'b0; slxylast = 1'b0;
    #1;
    check("t4_rd0", 64'(port_yvalid), 64'h4);
    check("t4_rd0_last", 64'(port_ylast), 64'h0);
    @(negedge clk);
    slxywreply = 1'b1; slxylast = 1'b1;
    #1;
    check("t4_wr", 64'(port_yvalid), 64'h2);
    check("t4_wr_last", 64'(port_ylast), 64'h2);
    @(negedge clk);
    slxywreply = 1'b0;
    #1;
    check("t4_rd1", 64'(port_yvalid), 64'h4);
    check("t4_rd1_last", 64'(port_ylast), 64'h4);
    @(negedge clk);
    slxyvalid = 1'b0;
    #1;
    check("t4_idle", 64'(busy), 64'd0);

    // Fill RFIFO, 9th read stalls, write from port 3 still proceeds
    set_qdata(0, 64'h4000);
    set_qdata(3, 64'h5001);
    port_qlast = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      port_qvalid = 4'b0001;
      #1;
      check("t3_fill", 64'(port_qdready), 64'h03);
    end
    @(negedge clk);
    port_qvalid = 4'b1001;
    #1;
    check("t3_write_past_full", 64'(port_qdready), 64'hC0);
    @(negedge clk);
    port_qvalid = 4'b0001;
    #1;
    check("t3_stall_rdy", 64'(port_qdready), 64'h00);
    check("t3_stall_valid", 64'(slxqvalid), 64'd0);
    @(negedge clk);
    port_qvalid = '0;
    slxyvalid = 1'b1; slxywreply = 1'b0; slxylast = 1'b1;
    #1;
    check("t3_free_resp", 64'(port_yvalid), 64'h1);
    @(negedge clk);
    slxyvalid   = 1'b0;
    port_qvalid = 4'b0001;
    #1;
    check("t3_unstall", 64'(port_qdready), 64'h03);
    @(negedge clk);
    port_qvalid = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      slxyvalid = 1'b1; slxywreply = 1'b0; slxylast = 1'b1;
      #1;
      check("t3_drain", 64'(port_yvalid), 64'h1);
    end
    @(negedge clk);
    slxywreply = 1'b1;
    #1;
    check("t3_wreply", 64'(port_yvalid), 64'h8);
    @(negedge clk);
    slxyvalid = 1'b0; slxywreply = 1'b0;
    #1;
    check("t3_idle", 64'(busy), 64'd0);

    // Write reply with empty WFIFO is drained and flagged; clear resets the flag
    @(negedge clk);
    slxyvalid = 1'b1; slxywreply = 1'b1; slxylast = 1'b1;
    #1;
    check("t5_drain_rdy", 64'(slxydready), 64'h3);
    check("t5_no_route", 64'(port_yvalid), 64'h0);
    @(negedge clk);
    slxyvalid = 1'b0; slxywreply = 1'b0;
    #1;
    check("t5_unexp_set", 64'(unexpected_resp), 64'd1);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("t5_unexp_clr", 64'(unexpected_resp), 64'd0);

    // rr_ptr moved to 3 via a port 2 grant, then ports 0 and 3 contend
    set_qdata(2, 64'h3000);
    set_qdata(0, 64'h4000);
    set_qdata(3, 64'h5000);
    port_qlast = 4'hF;
    @(negedge clk);
    port_qvalid = 4'b0100;
    #1;
    check("t6_p2", 64'(port_qdready), 64'h30);
    @(negedge clk);
    port_qvalid = 4'b1001;
    #1;
`ifdef DCA_LSU_MERGER_PRIORITY_EN
    check("t6_first", 64'(port_qdready), 64'h03);
`else
    check("t6_first", 64'(port_qdready), 64'hC0);
`endif
    @(negedge clk);
    #1;
    check("t6_second", 64'(port_qdready), 64'h03);
    @(negedge clk);
    #1;
`ifdef DCA_LSU_MERGER_PRIORITY_EN
    check("t6_third", 64'(port_qdready), 64'h03);
`else
    check("t6_third", 64'(port_qdready), 64'hC0);
`endif
    @(negedge clk);
    port_qvalid = '0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("t6_clear_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
